// File: rtl/and_ic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : and_ic_pkg
//  Purpose  : Shared constants for the quad 2-input AND gate input stage:
//             channel count, default debounce length and operand bit indices.
//  Revision : 1.0  initial release
// ============================================================================
package and_ic_pkg;

    // One channel per operand pin: four gates, two operands each.
    localparam int AND_IC_CHANNELS         = 8;

    // Default number of synchronised cycles a new level must persist.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Operand bit positions within the debounced bus (bit 2k = kA, 2k+1 = kB).
    localparam int GATE1_A = 0;
    localparam int GATE1_B = 1;
    localparam int GATE2_A = 2;
    localparam int GATE2_B = 3;
    localparam int GATE3_A = 4;
    localparam int GATE3_B = 5;
    localparam int GATE4_A = 6;
    localparam int GATE4_B = 7;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Purpose  : Single-bit 2-flop synchroniser followed by a saturating
//             counter debouncer with one-cycle rise/fall strobes.
//  Revision : 1.0  initial release
// ============================================================================
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic idle
);

    // Terminal count: a mismatch seen at this count is accepted on this edge.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Synchronise the pin, then count consecutive mismatches against the
    // accepted level; any return to the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            // Synchroniser runs regardless of enable.
            s1   <= raw;
            s2   <= s1;
            // Strobes last a single cycle; disabled cycles also squash them.
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                if (s2 == clean) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    clean <= s2;
                    cnt   <= '0;
                    rise  <= s2;
                    fall  <= ~s2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Channel is settled when the synced pin agrees and nothing is counting.
    always_comb begin
        idle = (s2 == clean) && (cnt == '0);
    end

endmodule
`default_nettype wire

// File: rtl/and_ic_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : and_ic_input_debouncer
//  Purpose  : Conditions the raw operand pins of the quad AND gate: per-bit
//             synchroniser + debouncer, edge strobes and an all-settled flag.
//  Revision : 1.0  initial release
// ============================================================================
module and_ic_input_debouncer
    import and_ic_pkg::*;
#(
    parameter int WIDTH           = AND_IC_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             stable
);

    // Counter width follows the debounce length; not independently tunable.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] idle;

    // One independent debouncer per operand pin.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .raw   (raw_in[i]),
            .clean (clean_out[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .idle  (idle[i])
        );
    end

    // Summary flags are derived purely from registered channel state.
    always_comb begin
        changed = |(rise | fall);
        stable  = &idle;
    end

endmodule
`default_nettype wire

// File: tb/tb_and_ic_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_and_ic_input_debouncer
//  Purpose  : Directed self-checking bench for and_ic_input_debouncer with a
//             short debounce length, plus a hold-constrained random phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_and_ic_input_debouncer;

    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] raw_in;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
    logic         stable;

    int checks = 0;
    int errors = 0;

    and_ic_input_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed),
        .stable    (stable)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [W-1:0] q[$];
    logic [W-1:0] exp_clean;
    logic [W-1:0] prev_clean;
    int           hold_left[W];

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        raw_in = 8'h00;
        tick();
        // Reset state
        chk("rst_clean",   clean_out, 8'h00);
        chk("rst_rise",    rise,      8'h00);
        chk("rst_fall",    fall,      8'h00);
        chk("rst_changed", 8'(changed), 8'h00);
        chk("rst_stable",  8'(stable),  8'h01);
        rst = 1'b0;

        // Quiet input after reset release
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_clean",  clean_out, 8'h00);
            chk("idle_rf",     rise | fall, 8'h00);
            chk("idle_stable", 8'(stable), 8'h01);
        end

        // Two-bit rise: accepted at edge 5, strobe for one cycle
        raw_in = 8'h03;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e < 5) chk("rise_pre_clean", clean_out, 8'h00);
            if (e >= 2 && e <= 4) chk("rise_pre_stable", 8'(stable), 8'h00);
            if (e == 5) begin
                chk("rise_clean",   clean_out,   8'h03);
                chk("rise_strobe",  rise,        8'h03);
                chk("rise_fall",    fall,        8'h00);
                chk("rise_changed", 8'(changed), 8'h01);
            end
            if (e == 6) begin
                chk("rise_after_strobe",  rise,        8'h00);
                chk("rise_after_changed", 8'(changed), 8'h00);
                chk("rise_after_stable",  8'(stable),  8'h01);
                chk("rise_after_clean",   clean_out,   8'h03);
            end
        end

        // Three-cycle glitch on bit 4 must be rejected
        raw_in = 8'h13;
        tick(); tick(); tick();
        raw_in = 8'h03;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("glitch_clean", clean_out, 8'h03);
            chk("glitch_rise",  rise,      8'h00);
        end
        // Same bit held long enough is accepted at edge 5
        raw_in = 8'h13;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e < 5)  chk("hold4_pre_clean", clean_out, 8'h03);
            if (e == 5) begin
                chk("hold4_clean", clean_out, 8'h13);
                chk("hold4_rise",  rise,      8'h10);
            end
            if (e == 6) chk("hold4_rise_clear", rise, 8'h00);
        end

        // Drive all ones, then freeze with en=0 while pins drop
        raw_in = 8'hFF;
        for (int k = 0; k < 8; k++) tick();
        chk("ff_clean", clean_out, 8'hFF);
        en     = 1'b0;
        raw_in = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("en0_clean", clean_out, 8'hFF);
            chk("en0_fall",  fall,      8'h00);
        end
        chk("en0_stable", 8'(stable), 8'h00);
        en = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e < 4) chk("en1_pre_clean", clean_out, 8'hFF);
            if (e == 4) begin
                chk("en1_clean",   clean_out,   8'h00);
                chk("en1_fall",    fall,        8'hFF);
                chk("en1_rise",    rise,        8'h00);
                chk("en1_changed", 8'(changed), 8'h01);
            end
            if (e == 5) chk("en1_fall_clear", fall, 8'h00);
        end

        // Reset mid-count: establish bit 7, then count bit 0 to 2 and reset
        raw_in = 8'h80;
        for (int k = 0; k < 8; k++) tick();
        chk("pre_rst_clean", clean_out, 8'h80);
        raw_in = 8'h81;
        for (int e = 0; e <= 3; e++) tick();
        chk("midcnt_clean", clean_out, 8'h80);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_clean",  clean_out,   8'h00);
        chk("midrst_fall",   fall,        8'h00);
        chk("midrst_rise",   rise,        8'h00);
        chk("midrst_stable", 8'(stable),  8'h01);
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (e < 5)  chk("redrive_pre_clean", clean_out, 8'h00);
            if (e == 5) begin
                chk("redrive_clean", clean_out, 8'h81);
                chk("redrive_rise",  rise,      8'h81);
            end
        end

        // Random toggling, each level held at least DC cycles: clean_out
        // then follows raw_in exactly, five edges late.
        rst    = 1'b1;
        raw_in = 8'h00;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) q.push_back(8'h00);
        for (int b = 0; b < W; b++) hold_left[b] = 0;
        prev_clean = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < W; b++) begin
                if (hold_left[b] == 0) begin
                    raw_in[b]    = ~raw_in[b];
                    hold_left[b] = $urandom_range(DC - 1, DC + 2);
                end else begin
                    hold_left[b] = hold_left[b] - 1;
                end
            end
            q.push_back(raw_in);
            tick();
            exp_clean = q.pop_front();
            chk("rand_clean", clean_out, exp_clean);
            chk("rand_rise",  rise, exp_clean & ~prev_clean);
            chk("rand_fall",  fall, ~exp_clean & prev_clean);
            chk("rand_both",  rise & fall, 8'h00);
            prev_clean = exp_clean;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
